// File: rtl/ret_stack.sv
// Parametrised LIFO for return addresses: circular storage, occupancy count, flags and error pulses.
// Optional macro RET_STACK_WRAP_EN: a push while full overwrites the oldest entry instead of dropping.
module ret_stack #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             ovf,
  output logic             unf
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] TpLast = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CntFull = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    tp_q, tp_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic [PW-1:0]    tp_inc, tp_dec;
  logic             we;
  logic [PW-1:0]    waddr;
  logic             is_empty, is_full;

  // Explicit wrap so non-power-of-two depths index correctly.
  assign tp_inc   = (tp_q == TpLast) ? '0 : tp_q + 1'b1;
  assign tp_dec   = (tp_q == '0) ? TpLast : tp_q - 1'b1;
  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CntFull);

  always_comb begin
    tp_d    = tp_q;
    count_d = count_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    we      = 1'b0;
    waddr   = tp_q;
    unique case ({push, pop})
      2'b10: begin
        if (!is_full) begin
          we      = 1'b1;
          waddr   = tp_inc;
          tp_d    = tp_inc;
          count_d = count_q + 1'b1;
        end else begin
`ifdef RET_STACK_WRAP_EN
          we      = 1'b1;
          waddr   = tp_inc;
          tp_d    = tp_inc;
`endif
          ovf_d   = 1'b1;
        end
      end
      2'b01: begin
        if (!is_empty) begin
          tp_d    = tp_dec;
          count_d = count_q - 1'b1;
        end else begin
          unf_d   = 1'b1;
        end
      end
      2'b11: begin
        if (!is_empty) begin
          // Replace top: depth is unchanged, so never an overflow.
          we      = 1'b1;
          waddr   = tp_q;
        end else begin
          we      = 1'b1;
          waddr   = tp_inc;
          tp_d    = tp_inc;
          count_d = CW'(1);
          unf_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem_d[i] = mem_q[i];
    end
    if (we) begin
      mem_d[waddr] = din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      tp_q    <= TpLast;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= mem_d[i];
      end
      tp_q    <= tp_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign top   = is_empty ? '0 : mem_q[tp_q];
  assign count = count_q;
  assign empty = is_empty;
  assign full  = is_full;
  assign ovf   = ovf_q;
  assign unf   = unf_q;

  a_pulses_exclusive: assert property (@(posedge clk) disable iff (!rst_n) !(ovf_q && unf_q));
  a_count_bounded: assert property (@(posedge clk) disable iff (!rst_n) count_q <= CntFull);

endmodule

// File: tb/tb_ret_stack.sv
// Scoreboard bench for ret_stack: a DEPTH=4 instance for directed cases and a DEPTH=3 instance for wrap.
module tb_ret_stack;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        push4, pop4, push3, pop3;
  logic [11:0] din4, din3, top4, top3;
  logic [2:0]  count4;
  logic [1:0]  count3;
  logic        empty4, full4, ovf4, unf4;
  logic        empty3, full3, ovf3, unf3;

  ret_stack #(.WIDTH(12), .DEPTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .push(push4), .pop(pop4), .din(din4), .top(top4),
    .count(count4), .empty(empty4), .full(full4), .ovf(ovf4), .unf(unf4)
  );

  ret_stack #(.WIDTH(12), .DEPTH(3)) u3 (
    .clk(clk), .rst_n(rst_n), .push(push3), .pop(pop3), .din(din3), .top(top3),
    .count(count3), .empty(empty3), .full(full3), .ovf(ovf3), .unf(unf3)
  );

  typedef struct {
    bit    inst;
    int    top;
    int    cnt;
    bit    ovf;
    bit    unf;
    string name;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares every queued expectation against the outputs one half-cycle after the edge.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        int   depth;
        e = exp_q.pop_front();
        depth = e.inst ? 3 : 4;
        if (!e.inst) begin
          chk({e.name, ".top"}, int'(top4), e.top);
          chk({e.name, ".count"}, int'(count4), e.cnt);
          chk({e.name, ".empty"}, int'(empty4), int'(e.cnt == 0));
          chk({e.name, ".full"}, int'(full4), int'(e.cnt == depth));
          chk({e.name, ".ovf"}, int'(ovf4), int'(e.ovf));
          chk({e.name, ".unf"}, int'(unf4), int'(e.unf));
        end else begin
          chk({e.name, ".top"}, int'(top3), e.top);
          chk({e.name, ".count"}, int'(count3), e.cnt);
          chk({e.name, ".empty"}, int'(empty3), int'(e.cnt == 0));
          chk({e.name, ".full"}, int'(full3), int'(e.cnt == depth));
          chk({e.name, ".ovf"}, int'(ovf3), int'(e.ovf));
          chk({e.name, ".unf"}, int'(unf3), int'(e.unf));
        end
      end
    end
  end

  task automatic step(input bit inst, input bit p, input bit q, input logic [11:0] d,
                      input int etop, input int ecnt, input bit eovf, input bit eunf,
                      input string name);
    exp_t e;
    @(negedge clk);
    #1;
    if (!inst) begin
      push4 = p; pop4 = q; din4 = d;
    end else begin
      push3 = p; pop3 = q; din3 = d;
    end
    @(posedge clk);
    e.inst = inst; e.top = etop; e.cnt = ecnt; e.ovf = eovf; e.unf = eunf; e.name = name;
    exp_q.push_back(e);
    #1;
    if (!inst) begin
      push4 = 1'b0; pop4 = 1'b0;
    end else begin
      push3 = 1'b0; pop3 = 1'b0;
    end
  endtask

  int model[$];

  initial begin
    rst_n = 1'b0;
    push4 = 1'b0; pop4 = 1'b0; din4 = '0;
    push3 = 1'b0; pop3 = 1'b0; din3 = '0;
    #2;
    chk("rst.top", int'(top4), 0);
    chk("rst.count", int'(count4), 0);
    chk("rst.empty", int'(empty4), 1);
    chk("rst.full", int'(full4), 0);
    chk("rst.ovf", int'(ovf4), 0);
    chk("rst.unf", int'(unf4), 0);
    #10 rst_n = 1'b1;

    // Basic push/pop
    step(0, 1, 0, 12'h123, 'h123, 1, 0, 0, "push123");
    step(0, 1, 0, 12'h456, 'h456, 2, 0, 0, "push456");
    step(0, 0, 1, 12'h000, 'h123, 1, 0, 0, "pop1");
    step(0, 0, 1, 12'h000, 0,     0, 0, 0, "pop2");

    // Fill, then push while full
    step(0, 1, 0, 12'd1, 1, 1, 0, 0, "fill1");
    step(0, 1, 0, 12'd2, 2, 2, 0, 0, "fill2");
    step(0, 1, 0, 12'd3, 3, 3, 0, 0, "fill3");
    step(0, 1, 0, 12'd4, 4, 4, 0, 0, "fill4");
`ifdef RET_STACK_WRAP_EN
    step(0, 1, 0, 12'd5, 5, 4, 1, 0, "push_full");
    step(0, 0, 0, 12'd0, 5, 4, 0, 0, "ovf_drop");
    step(0, 0, 1, 12'd0, 4, 3, 0, 0, "drain1");
    step(0, 0, 1, 12'd0, 3, 2, 0, 0, "drain2");
    step(0, 0, 1, 12'd0, 2, 1, 0, 0, "drain3");
`else
    step(0, 1, 0, 12'd5, 4, 4, 1, 0, "push_full");
    step(0, 0, 0, 12'd0, 4, 4, 0, 0, "ovf_drop");
    step(0, 0, 1, 12'd0, 3, 3, 0, 0, "drain1");
    step(0, 0, 1, 12'd0, 2, 2, 0, 0, "drain2");
    step(0, 0, 1, 12'd0, 1, 1, 0, 0, "drain3");
`endif
    step(0, 0, 1, 12'd0, 0, 0, 0, 0, "drain4");

    // Underflow and push+pop on empty
    step(0, 0, 1, 12'd0,   0,     0, 0, 1, "pop_empty");
    step(0, 0, 0, 12'd0,   0,     0, 0, 0, "unf_drop");
    step(0, 1, 1, 12'hABC, 'hABC, 1, 0, 1, "pushpop_empty");
    step(0, 0, 1, 12'd0,   0,     0, 0, 0, "pop_abc");

    // Replace top while full
    step(0, 1, 0, 12'd1,   1,     1, 0, 0, "refill1");
    step(0, 1, 0, 12'd2,   2,     2, 0, 0, "refill2");
    step(0, 1, 0, 12'd3,   3,     3, 0, 0, "refill3");
    step(0, 1, 0, 12'd4,   4,     4, 0, 0, "refill4");
    step(0, 1, 1, 12'h777, 'h777, 4, 0, 0, "replace_full");
    step(0, 0, 1, 12'd0,   3,     3, 0, 0, "rpop1");
    step(0, 0, 1, 12'd0,   2,     2, 0, 0, "rpop2");
    step(0, 0, 1, 12'd0,   1,     1, 0, 0, "rpop3");
    step(0, 0, 1, 12'd0,   0,     0, 0, 0, "rpop4");

    // Asynchronous reset between edges with three entries held
    step(0, 1, 0, 12'h00A, 'h00A, 1, 0, 0, "pre_rst1");
    step(0, 1, 0, 12'h00B, 'h00B, 2, 0, 0, "pre_rst2");
    step(0, 1, 0, 12'h00C, 'h00C, 3, 0, 0, "pre_rst3");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.top", int'(top4), 0);
    chk("arst.count", int'(count4), 0);
    chk("arst.empty", int'(empty4), 1);
    #1 rst_n = 1'b1;
    step(0, 1, 0, 12'h5A5, 'h5A5, 1, 0, 0, "post_rst");

    // DEPTH=3 wrap: each group of six pushes three then pops three, carrying tp past 2->0
    for (int it = 0; it < 10; it++) begin
      for (int k = 0; k < 6; k++) begin
        logic [11:0] d;
        bit          p;
        d = 12'(it * 16 + k + 1);
        p = (k < 3);
        if (p) begin
          if (model.size() < 3) model.push_back(int'(d));
        end else begin
          if (model.size() > 0) void'(model.pop_back());
        end
        step(1, p, !p, d, (model.size() > 0) ? model[$] : 0, model.size(), 0, 0, "wrap3");
      end
    end

    repeat (3) @(negedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ret_stack.md
Name: ret_stack

Overview:
- Parametrised LIFO for return addresses and temporary data. Successor to the fixed 4-entry, 12-bit stack and its separate index counter.
- Merges storage and index into one block, with configurable width and depth.
- Adds async reset, occupancy count, full/empty flags, overflow/underflow pulses and combined push+pop (replace top).
- Sits beside the PC logic: push on call (din = return PC), pop on return (top = return PC).

Parameters:
- WIDTH, 12, data/address width in bits.
- DEPTH, 4, number of entries; any integer >= 2, power of two not required.
- CW (localparam), $clog2(DEPTH+1), width of count.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- push  input  1  push request, sampled at clk rise.
- pop  input  1  pop request, sampled at clk rise.
- din  input  WIDTH  data to push.
- top  output  WIDTH  current top-of-stack entry; 0 when empty.
- count  output  CW  number of valid entries, 0..DEPTH.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- ovf  output  1  one-cycle pulse: push refused (or oldest entry lost, see feature).
- unf  output  1  one-cycle pulse: pop on empty stack.

Behaviour:
- Reset (rst_n low, async): count=0, top pointer tp=DEPTH-1, all storage=0, ovf=0, unf=0. Outputs: top=0, empty=1, full=0. Takes effect immediately mid-operation; requests in flight are lost.
- Storage is a circular buffer of DEPTH entries. tp indexes the top entry. Next write slot is (tp+1) mod DEPTH, with explicit wrap (no reliance on power-of-two overflow).
- top is combinational from registered state: mem[tp] when count>0, else 0. A pushed value appears on top the cycle after the push edge (1-cycle latency).
- Per clock edge, priority by (push, pop, state):
  - no request: state holds; ovf=unf=0.
  - push only, not full: mem[(tp+1) mod DEPTH] <= din, tp advances, count+1.
  - push only, full: din dropped, state holds, ovf=1 for one cycle.
  - pop only, not empty: tp retreats (mod DEPTH), count-1. Storage is not cleared.
  - pop only, empty: state holds, unf=1 for one cycle.
  - push and pop, not empty: mem[tp] <= din, count and tp unchanged (replace top). No ovf even if full.
  - push and pop, empty: push executes (count becomes 1), pop ignored, unf=1.
- ovf/unf are registered, high only in the cycle after the offending edge, and never both high.
- count never exceeds DEPTH or goes below 0.

Optional Feature:
- Macro: RET_STACK_WRAP_EN.
- Defined: push-only while full overwrites the oldest entry. mem[(tp+1) mod DEPTH] <= din, tp advances, count stays DEPTH, ovf=1 (signals lost entry). Suits deep recursion where only recent returns matter.
- Not defined: push while full is dropped as above. Storage and tp unchanged.

Test Plan:
- Reset, then push 0x123, 0x456 on consecutive cycles -> count=2, top=0x456, empty=0. Pop -> top=0x123, count=1. Pop -> empty=1, top=0.
- DEPTH=4: push 1,2,3,4 -> full=1. Push 5 -> ovf pulse 1 cycle, top=4, count=4 (macro off). With macro on: top=5; pops return 5,4,3,2, then empty.
- Empty stack, pop -> unf high exactly one cycle, count stays 0, top=0. Then push+pop with din=0xABC -> count=1, top=0xABC, unf=1.
- Full stack (1,2,3,4), push+pop din=0x777 -> top=0x777, count=4, ovf=0. Pops yield 0x777,3,2,1.
- Wrap check, DEPTH=3 (non-power-of-two): push/pop pattern driving tp across index 2->0 ten times -> LIFO order always correct versus a reference model.
- Assert rst_n low mid-stream with count=3, between clock edges -> count=0, empty=1, top=0 immediately, without waiting for a clock edge. Next push returns its own data.
